// File: rtl/fa.sv
// fa: registered ripple-carry full adder.
// {carry, sum} = a + b + cin, one cycle after sampling.
module fa #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_d;
  logic             carry_q;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c     = '0;
    sum_d = '0;
    c[0]  = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i] = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i])
               | (a[i] & c[i])
               | (b[i] & c[i]);
    end
    carry_d = c[WIDTH];
  end

  // Output registers; reset wins over the new result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_fa.sv
// tb_fa: scoreboard bench for fa at WIDTH=1 and WIDTH=4.
// Expected values come from integer addition of the operands.
module tb_fa;

  logic       clk;
  logic       rst_n;
  logic       cin;
  logic       a1, b1;
  logic [3:0] a4, b4;
  logic       s1, c1;
  logic [3:0] s4;
  logic       c4;

  typedef struct {
    logic [3:0] s4;
    logic       c4;
    logic       s1;
    logic       c1;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  bit   done;

  fa #(.WIDTH(1)) u_fa1 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a1),
    .b    (b1),
    .cin  (cin),
    .sum  (s1),
    .carry(c1)
  );

  fa #(.WIDTH(4)) u_fa4 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a4),
    .b    (b4),
    .cin  (cin),
    .sum  (s4),
    .carry(c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(
    input logic       r,
    input logic [3:0] va4,
    input logic [3:0] vb4,
    input logic       va1,
    input logic       vb1,
    input logic       vc,
    input string      tag
  );
    exp_t e;
    int   t4, t1;
    @(negedge clk);
    rst_n = r;
    a4    = va4;
    b4    = vb4;
    a1    = va1;
    b1    = vb1;
    cin   = vc;
    t4 = int'(va4) + int'(vb4) + int'(vc);
    t1 = int'(va1) + int'(vb1) + int'(vc);
    if (!r) begin
      t4 = 0;
      t1 = 0;
    end
    e.s4  = 4'(t4 % 16);
    e.c4  = (t4 / 16) != 0;
    e.s1  = 1'(t1 % 2);
    e.c1  = (t1 / 2) != 0;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: every edge after stimulus starts yields one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_chk += 2;
        if (s1 !== e.s1 || c1 !== e.c1) begin
          n_fail++;
          $display("FAIL w1 %s: got sum=%b carry=%b want sum=%b carry=%b",
                   e.tag, s1, c1, e.s1, e.c1);
        end
        if (s4 !== e.s4 || c4 !== e.c4) begin
          n_fail++;
          $display("FAIL w4 %s: got sum=%h carry=%b want sum=%h carry=%b",
                   e.tag, s4, c4, e.s4, e.c4);
        end
      end
    end
  end

  initial begin
    logic [2:0] v;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    a1 = 0; b1 = 0; a4 = 0; b4 = 0; cin = 0;

    drive(0, 4'hF, 4'hF, 1, 1, 1, "reset0");
    drive(0, 4'hF, 4'hF, 1, 1, 1, "reset1");
    drive(1, 4'hF, 4'hF, 1, 1, 1, "release");
    drive(1, 4'h0, 4'h0, 0, 0, 0, "zeros");
    drive(1, 4'hF, 4'hF, 1, 1, 1, "ones");
    drive(1, 4'h3, 4'h4, 1, 0, 0, "mix100");
    drive(1, 4'h9, 4'h6, 0, 1, 1, "mix011");

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(1, 4'(i), 4'(7 - i), v[2], v[1], v[0], "sweep");
    end

    drive(1, 4'hF, 4'h1, 0, 1, 0, "w4wrap");
    drive(1, 4'hF, 4'hF, 1, 1, 1, "w4max");
    drive(1, 4'h8, 4'h8, 0, 0, 0, "w4carry");

    for (int i = 0; i < 200; i++) begin
      drive(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "rand");
      if (i == 100) begin
        drive(0, 4'hA, 4'h7, 1, 1, 1, "midrst");
        drive(1, 4'hA, 4'h7, 1, 1, 1, "resume");
      end
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
